wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 26 ++
 rtl/wb_load_align.sv | 36 +++
 rtl/wb_stage.sv | 129 ++++++++++++
 tb/tb_wb_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared constants and payload types for the writeback stage.
// FSM state encodings and load funct3 encodings live here so every user agrees on them.
package wb_stage_pkg;

  localparam int unsigned ST_W    = 2;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned ALO_W   = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_COMMIT = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT   = 2'd2;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // Control captured for a load while its data is outstanding.
  typedef struct packed {
    logic              we;
    logic [F3_W-1:0]   funct3;
    logic [ALO_W-1:0]  addr_lo;
  } ld_ctrl_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load alignment: selects byte/halfword/word from the memory
// word and sign- or zero-extends it to XLEN.
module wb_load_align
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [F3_W-1:0]  funct3,
  input  logic [ALO_W-1:0] addr_lo,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  load_value_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  byte_shift;

  // Halfwords ignore addr_lo[0]; words ignore addr_lo entirely.
  always_comb begin
    byte_shift = {addr_lo, 3'b000};
    byte_sel   = 8'(rdata >> byte_shift);
    half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_value_c = rdata;
    case (funct3)
      F3_LB:   load_value_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   load_value_c = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  load_value_c = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  load_value_c = {{(XLEN-16){1'b0}}, half_sel};
      default: load_value_c = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results and aligned load data into the register file.
// Optional forwarding outputs are enabled with the WB_BYPASS_EN macro.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_we,
  input  logic             in_is_load,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             write_en,
  output logic [RD_W-1:0]  write_addr,
  output logic [XLEN-1:0]  write_value,
  output logic             busy
`ifdef WB_BYPASS_EN
  ,
  output logic             fwd_valid,
  output logic [RD_W-1:0]  fwd_addr,
  output logic [XLEN-1:0]  fwd_value,
  output logic             fwd_pending,
  output logic [RD_W-1:0]  fwd_pending_addr
`endif
);

  logic [ST_W-1:0] state, state_nxt;
  logic            write_en_nxt;
  logic [RD_W-1:0] write_addr_nxt;
  logic [XLEN-1:0] write_value_nxt;
  logic [RD_W-1:0] pend_rd, pend_rd_nxt;
  ld_ctrl_t        pend_ctrl, pend_ctrl_nxt;
  logic            transfer;
  logic [XLEN-1:0] load_value_c;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .funct3       (pend_ctrl.funct3),
    .addr_lo      (pend_ctrl.addr_lo),
    .rdata        (dmem_rdata),
    .load_value_c (load_value_c)
  );

  assign transfer = in_valid && in_ready;

  // Next-state and next-output decode; write_en only fires on the cycle entering COMMIT.
  always_comb begin
    state_nxt       = state;
    write_en_nxt    = 1'b0;
    write_addr_nxt  = write_addr;
    write_value_nxt = write_value;
    pend_rd_nxt     = pend_rd;
    pend_ctrl_nxt   = pend_ctrl;
    case (state)
      ST_IDLE, ST_COMMIT: begin
        state_nxt = ST_IDLE;
        if (transfer) begin
          if (in_is_load) begin
            pend_rd_nxt           = in_rd;
            pend_ctrl_nxt.we      = in_we;
            pend_ctrl_nxt.funct3  = in_funct3;
            pend_ctrl_nxt.addr_lo = in_addr_lo;
            state_nxt             = ST_WAIT;
          end else begin
            write_en_nxt    = in_we && (in_rd != '0);
            write_addr_nxt  = in_rd;
            write_value_nxt = in_alu_result;
            state_nxt       = ST_COMMIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          write_en_nxt    = pend_ctrl.we && (pend_rd != '0);
          write_addr_nxt  = pend_rd;
          write_value_nxt = load_value_c;
          state_nxt       = ST_COMMIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      write_en    <= 1'b0;
      write_addr  <= '0;
      write_value <= '0;
      pend_rd     <= '0;
      pend_ctrl   <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      write_en    <= write_en_nxt;
      write_addr  <= write_addr_nxt;
      write_value <= write_value_nxt;
      pend_rd     <= pend_rd_nxt;
      pend_ctrl   <= pend_ctrl_nxt;
      in_ready    <= (state_nxt != ST_WAIT);
      busy        <= (state_nxt == ST_WAIT);
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_valid        = write_en;
  assign fwd_addr         = write_addr;
  assign fwd_value        = write_value;
  assign fwd_pending_addr = pend_rd;

  // Pending-load hint for the hazard unit: a load that will write a real register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_pending <= 1'b0;
    end else begin
      fwd_pending <= (state_nxt == ST_WAIT) && pend_ctrl_nxt.we && (pend_rd_nxt != '0);
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_we;
  logic        in_is_load;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_value;
  logic        busy;
`ifdef WB_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_value;
  logic        fwd_pending;
  logic [4:0]  fwd_pending_addr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_we         (in_we),
    .in_is_load    (in_is_load),
    .in_rd         (in_rd),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_alu_result (in_alu_result),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .write_en      (write_en),
    .write_addr    (write_addr),
    .write_value   (write_value),
    .busy          (busy)
`ifdef WB_BYPASS_EN
    ,
    .fwd_valid        (fwd_valid),
    .fwd_addr         (fwd_addr),
    .fwd_value        (fwd_value),
    .fwd_pending      (fwd_pending),
    .fwd_pending_addr (fwd_pending_addr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_we         = 1'b0;
    in_is_load    = 1'b0;
    in_rd         = '0;
    in_funct3     = '0;
    in_addr_lo    = '0;
    in_alu_result = '0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = '0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic we, input logic [31:0] val);
    in_valid      = 1'b1;
    in_is_load    = 1'b0;
    in_we         = we;
    in_rd         = rd;
    in_alu_result = val;
  endtask

  // Issue a load, wait gap cycles, return rdata; leaves the bench right after the rvalid edge.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [4:0] rd, input logic [31:0] rdata, input int gap,
                         input logic [31:0] exp);
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_we      = 1'b1;
    in_rd      = rd;
    in_funct3  = f3;
    in_addr_lo = lo;
    step();
    idle_inputs();
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    for (int i = 1; i < gap; i++) begin
      step();
      check({tag, " wait no write"}, 32'(write_en), 32'd0);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    step();
    dmem_rvalid = 1'b0;
    check({tag, " write_en"}, 32'(write_en), 32'd1);
    check({tag, " write_addr"}, 32'(write_addr), 32'(rd));
    check({tag, " write_value"}, write_value, exp);
    check({tag, " busy after"}, 32'(busy), 32'd0);
    step();
    check({tag, " write_en drop"}, 32'(write_en), 32'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst write_en", 32'(write_en), 32'd0);
    check("rst write_addr", 32'(write_addr), 32'd0);
    check("rst write_value", write_value, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);

    // Single ALU op, one-cycle latency
    alu_op(5'd5, 1'b1, 32'h1234_5678);
    step();
    idle_inputs();
    check("alu write_en", 32'(write_en), 32'd1);
    check("alu write_addr", 32'(write_addr), 32'd5);
    check("alu write_value", write_value, 32'h1234_5678);
    step();
    check("alu write_en one cycle", 32'(write_en), 32'd0);

    // rvalid while idle must be ignored
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    step();
    dmem_rvalid = 1'b0;
    check("stray rvalid", 32'(write_en), 32'd0);

    do_load("LB",  F3_LB,  2'd2, 5'd7,  32'h0080_FF00, 3, 32'hFFFF_FF80);
    do_load("LHU", F3_LHU, 2'd2, 5'd8,  32'hBEEF_1234, 1, 32'h0000_BEEF);
    do_load("LH",  F3_LH,  2'd3, 5'd9,  32'hBEEF_1234, 2, 32'hFFFF_BEEF);
    do_load("LBU", F3_LBU, 2'd1, 5'd10, 32'h0080_FF00, 1, 32'h0000_00FF);
    do_load("LW",  F3_LW,  2'd3, 5'd11, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
    do_load("F3_3", 3'b011, 2'd1, 5'd12, 32'h8765_4321, 1, 32'h8765_4321);

    // rd=0 and we=0 never write
    alu_op(5'd0, 1'b1, 32'h0000_DEAD);
    step();
    idle_inputs();
    check("rd0 write_en", 32'(write_en), 32'd0);
    alu_op(5'd3, 1'b0, 32'h0000_BEEF);
    step();
    idle_inputs();
    check("we0 write_en", 32'(write_en), 32'd0);
    step();

    // Back-to-back ALU ops: one write per cycle, no bubble
    for (int i = 1; i <= 4; i++) begin
      alu_op(5'(i), 1'b1, 32'(i) * 32'h1111_1111);
      step();
      check("b2b write_en", 32'(write_en), 32'd1);
      check("b2b write_addr", 32'(write_addr), 32'(i));
      check("b2b write_value", write_value, 32'(i) * 32'h1111_1111);
      check("b2b in_ready", 32'(in_ready), 32'd1);
    end
    idle_inputs();
    step();
    check("b2b end", 32'(write_en), 32'd0);

    // Reset during WAIT discards the pending load
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_we      = 1'b1;
    in_rd      = 5'd9;
    in_funct3  = F3_LW;
    step();
    idle_inputs();
    check("rstwait busy", 32'(busy), 32'd1);
`ifdef WB_BYPASS_EN
    check("fwd_pending", 32'(fwd_pending), 32'd1);
    check("fwd_pending_addr", 32'(fwd_pending_addr), 32'd9);
`endif
    reset       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hAAAA_5555;
    alu_op(5'd6, 1'b1, 32'h0000_0066);
    step();
    reset = 1'b0;
    idle_inputs();
    check("rstwait prio write_en", 32'(write_en), 32'd0);
    check("rstwait busy clr", 32'(busy), 32'd0);
    check("rstwait in_ready", 32'(in_ready), 32'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hAAAA_5555;
    step();
    dmem_rvalid = 1'b0;
    check("rstwait late rvalid", 32'(write_en), 32'd0);
    check("rstwait idle", 32'(busy), 32'd0);
    check("rstwait value", write_value, 32'd0);

`ifdef WB_BYPASS_EN
    alu_op(5'd13, 1'b1, 32'h0BAD_F00D);
    step();
    idle_inputs();
    check("fwd_valid", 32'(fwd_valid), 32'd1);
    check("fwd_addr", 32'(fwd_addr), 32'd13);
    check("fwd_value", fwd_value, 32'h0BAD_F00D);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
